// File: rtl/nvram_ctrl.sv
// nvram_ctrl: single-port 8 KiB battery-backed NVRAM shared between the
// 68070 CPU bus (one byte per CPU word, upper lane) and the HPS save/load
// port. One RAM access per granted request; CPU and HPS alternate on ties.
module nvram_ctrl #(
  parameter int    ADDR_W    = 13,
  parameter string INIT_FILE = ""
) (
  input  logic              clk30,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_uds,
  input  logic              cpu_lds,
  input  logic              cpu_write_strobe,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_bus_ack,
  input  logic [ADDR_W-1:0] hps_addr,
  input  logic              hps_rd,
  input  logic              hps_wr,
  input  logic [7:0]        hps_din,
  output logic [7:0]        hps_dout,
  output logic              hps_ack,
  output logic              hps_busy,
  output logic              dirty,
  input  logic              dirty_clear
);

  typedef enum logic [2:0] {
    IDLE,
    CPU_RD,
    CPU_DONE,
    HPS_RD,
    HPS_DONE
  } state_t;

  state_t            state;
  logic              last_hps;   // 1 = most recent grant went to the HPS
  logic              pend;       // HPS request pending or in service
  logic              pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [7:0]        rdata;

  logic              cpu_req;
  logic              hps_new;
  logic              hps_req;
  logic              hps_req_wr;
  logic [ADDR_W-1:0] hps_req_addr;
  logic [7:0]        hps_req_data;
  logic              grant_cpu;
  logic              grant_hps;
  logic              cpu_wr_now;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              unused_din_low;

  // The lower CPU data lane is never stored.
  assign unused_din_low = ^cpu_din[7:0];

  // Request decode, tie-break arbitration and the single RAM port mux
  always_comb begin
    cpu_req      = cpu_cs && (cpu_uds || cpu_lds);
    hps_new      = hps_rd || hps_wr;
    // A fresh pulse competes in the same cycle it arrives; the slot holds it afterwards.
    hps_req      = pend || hps_new;
    hps_req_wr   = pend ? pend_wr   : hps_wr;
    hps_req_addr = pend ? pend_addr : hps_addr;
    hps_req_data = pend ? pend_data : hps_din;
    grant_cpu    = (state == IDLE) && cpu_req && (!hps_req || last_hps);
    grant_hps    = (state == IDLE) && hps_req && (!cpu_req || !last_hps);
    cpu_wr_now   = grant_cpu && cpu_write_strobe && cpu_uds;
    ram_we       = 1'b0;
    ram_addr     = cpu_addr;
    ram_wdata    = cpu_din[15:8];
    if (grant_hps) begin
      ram_addr  = hps_req_addr;
      ram_wdata = hps_req_data;
      ram_we    = hps_req_wr && !reset;
    end else if (grant_cpu) begin
      ram_we    = cpu_write_strobe && cpu_uds && !reset;
    end
  end

  // DTACK follows chip select so it releases in the same cycle cs drops.
  assign cpu_bus_ack = (state == CPU_DONE) && cpu_cs;
  assign hps_busy    = pend;

  // Byte RAM: one synchronous access per cycle, contents survive reset
  always_ff @(posedge clk30) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata <= mem[ram_addr];
  end

  // Arbiter FSM, HPS request slot, dirty flag and registered read data
  always_ff @(posedge clk30) begin
    if (reset) begin
      state    <= IDLE;
      last_hps <= 1'b1;
      pend     <= 1'b0;
      hps_ack  <= 1'b0;
      dirty    <= 1'b0;
      cpu_dout <= 16'h0000;
      hps_dout <= 8'h00;
    end else begin
      hps_ack <= 1'b0;
      if (!pend && hps_new) begin
        pend      <= 1'b1;
        pend_wr   <= hps_wr;
        pend_addr <= hps_addr;
        pend_data <= hps_din;
      end
      if (cpu_wr_now) dirty <= 1'b1;
      else if (dirty_clear) dirty <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            last_hps <= 1'b0;
            state    <= cpu_write_strobe ? CPU_DONE : CPU_RD;
          end else if (grant_hps) begin
            last_hps <= 1'b1;
            if (hps_req_wr) begin
              state   <= HPS_DONE;
              hps_ack <= 1'b1;
            end else begin
              state   <= HPS_RD;
            end
          end
        end
        CPU_RD: begin
          cpu_dout <= {rdata, rdata};
          state    <= CPU_DONE;
        end
        CPU_DONE: begin
          if (!cpu_cs) state <= IDLE;
        end
        HPS_RD: begin
          hps_dout <= rdata;
          hps_ack  <= 1'b1;
          state    <= HPS_DONE;
        end
        HPS_DONE: begin
          pend  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_ctrl.sv
// tb_nvram_ctrl: directed plus randomized bench for nvram_ctrl with a
// byte-array reference of the NVRAM, dirty flag and tie-break history.
module tb_nvram_ctrl;
  localparam int ADDR_W = 13;

  logic              clk30 = 1'b0;
  logic              reset;
  logic              cpu_cs;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_uds;
  logic              cpu_lds;
  logic              cpu_write_strobe;
  logic [15:0]       cpu_din;
  logic [15:0]       cpu_dout;
  logic              cpu_bus_ack;
  logic [ADDR_W-1:0] hps_addr;
  logic              hps_rd;
  logic              hps_wr;
  logic [7:0]        hps_din;
  logic [7:0]        hps_dout;
  logic              hps_ack;
  logic              hps_busy;
  logic              dirty;
  logic              dirty_clear;

  int tests = 0;
  int fails = 0;

  logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] written [$];
  bit                ref_dirty;
  bit                ref_last_hps;

  always #5 clk30 = ~clk30;

  nvram_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk30(clk30), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds),
    .cpu_write_strobe(cpu_write_strobe), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_bus_ack(cpu_bus_ack),
    .hps_addr(hps_addr), .hps_rd(hps_rd), .hps_wr(hps_wr), .hps_din(hps_din),
    .hps_dout(hps_dout), .hps_ack(hps_ack), .hps_busy(hps_busy),
    .dirty(dirty), .dirty_clear(dirty_clear)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  // One CPU bus cycle: hold cs until DTACK, keep it one more cycle, release.
  task automatic cpu_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                            input bit u, input bit l, input bit dclr,
                            output logic [15:0] rd, output int lat);
    cpu_addr = a; cpu_din = d; cpu_write_strobe = wr; cpu_uds = u; cpu_lds = l;
    dirty_clear = dclr; cpu_cs = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      dirty_clear = 1'b0;
      if (cpu_bus_ack) begin
        lat = k;
        break;
      end
    end
    rd = cpu_dout;
    tick();
    chk("cpu_ack_hold", cpu_bus_ack, 1);
    cpu_cs = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_write_strobe = 1'b0;
    #1;
    chk("cpu_ack_release", cpu_bus_ack, 0);
    tick();
    ref_last_hps = 1'b0;
    if (wr && u) begin
      ref_mem[a] = d[15:8];
      written.push_back(a);
      ref_dirty = 1'b1;
    end else if (dclr) begin
      ref_dirty = 1'b0;
    end
  endtask

  task automatic cpu_check(input string tag, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [15:0] d, input bit u, input bit l, input bit dclr);
    logic [15:0] rd;
    logic [15:0] exp_rd;
    int lat;
    exp_rd = {ref_mem[a], ref_mem[a]};
    cpu_access(wr, a, d, u, l, dclr, rd, lat);
    chk({tag, "_lat"}, lat, wr ? 1 : 2);
    if (!wr) chk({tag, "_data"}, rd, exp_rd);
    chk({tag, "_dirty"}, dirty, ref_dirty);
  endtask

  // One HPS transfer: single-cycle pulse, wait for the completion pulse.
  task automatic hps_check(input string tag, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d);
    logic [7:0] rd;
    logic [7:0] exp_rd;
    int lat;
    exp_rd = ref_mem[a];
    hps_addr = a; hps_din = d; hps_wr = wr; hps_rd = !wr;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        hps_rd = 1'b0; hps_wr = 1'b0;
        chk({tag, "_busy_set"}, hps_busy, 1);
      end
      if (hps_ack) begin
        lat = k;
        break;
      end
    end
    rd = hps_dout;
    tick();
    chk({tag, "_ack_width"}, hps_ack, 0);
    chk({tag, "_busy_clr"}, hps_busy, 0);
    chk({tag, "_lat"}, lat, wr ? 1 : 2);
    if (!wr) chk({tag, "_data"}, rd, exp_rd);
    ref_last_hps = 1'b1;
    if (wr) begin
      ref_mem[a] = d;
      written.push_back(a);
    end
    chk({tag, "_dirty"}, dirty, ref_dirty);
  endtask

  // CPU request and HPS pulse presented in the same cycle.
  task automatic pair_check(input string tag,
                            input bit cwr, input logic [ADDR_W-1:0] ca, input logic [7:0] cd,
                            input bit hwr, input logic [ADDR_W-1:0] ha, input logic [7:0] hd);
    bit cpu_first;
    int cb, hb, exp_c, exp_h, cpu_t, hps_t;
    logic [15:0] cdout, exp_cdout;
    logic [7:0] hdout, exp_hdout;
    cpu_first = ref_last_hps;
    cb = cwr ? 1 : 2;
    hb = hwr ? 1 : 2;
    // Loser starts two cycles after the winner's completion cycle.
    exp_c = cpu_first ? cb : hb + cb + 1;
    exp_h = cpu_first ? cb + hb + 1 : hb;
    if (cpu_first) begin
      exp_cdout = {ref_mem[ca], ref_mem[ca]};
      if (cwr) begin ref_mem[ca] = cd; written.push_back(ca); end
      exp_hdout = ref_mem[ha];
      if (hwr) begin ref_mem[ha] = hd; written.push_back(ha); end
      ref_last_hps = 1'b1;
    end else begin
      exp_hdout = ref_mem[ha];
      if (hwr) begin ref_mem[ha] = hd; written.push_back(ha); end
      exp_cdout = {ref_mem[ca], ref_mem[ca]};
      if (cwr) begin ref_mem[ca] = cd; written.push_back(ca); end
      ref_last_hps = 1'b0;
    end
    if (cwr) ref_dirty = 1'b1;
    cpu_addr = ca; cpu_din = {cd, 8'h00}; cpu_write_strobe = cwr;
    cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_cs = 1'b1;
    hps_addr = ha; hps_din = hd; hps_wr = hwr; hps_rd = !hwr;
    cpu_t = 0; hps_t = 0; cdout = 16'h0; hdout = 8'h0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin hps_rd = 1'b0; hps_wr = 1'b0; end
      if (cpu_bus_ack && cpu_t == 0) begin
        cpu_t = k; cdout = cpu_dout;
        cpu_cs = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_write_strobe = 1'b0;
      end
      if (hps_ack && hps_t == 0) begin
        hps_t = k; hdout = hps_dout;
      end
      if (cpu_t != 0 && hps_t != 0) break;
    end
    cpu_cs = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_write_strobe = 1'b0;
    tick();
    chk({tag, "_cpu_t"}, cpu_t, exp_c);
    chk({tag, "_hps_t"}, hps_t, exp_h);
    if (!cwr) chk({tag, "_cpu_data"}, cdout, exp_cdout);
    if (!hwr) chk({tag, "_hps_data"}, hdout, exp_hdout);
    chk({tag, "_dirty"}, dirty, ref_dirty);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_dirty = 1'b0;
    ref_last_hps = 1'b1;
  endtask

  initial begin
    logic [15:0] hold_cpu;
    logic [7:0]  hold_hps;
    logic [ADDR_W-1:0] ra, rb;
    int op;
    reset = 1'b1; cpu_cs = 1'b0; cpu_addr = '0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    cpu_write_strobe = 1'b0; cpu_din = 16'h0; hps_addr = '0; hps_rd = 1'b0;
    hps_wr = 1'b0; hps_din = 8'h0; dirty_clear = 1'b0;
    ref_dirty = 1'b0; ref_last_hps = 1'b1;
    tick(); tick(); tick();
    chk("rst_cpu_ack", cpu_bus_ack, 0);
    chk("rst_hps_ack", hps_ack, 0);
    chk("rst_hps_busy", hps_busy, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_hps_dout", hps_dout, 0);
    reset = 1'b0;
    tick();

    // First tie after reset goes to the CPU; HPS served after cs drops.
    pair_check("pair1", 1'b1, 13'h0010, 8'hA5, 1'b1, 13'h1FFF, 8'h3C);
    cpu_check("cpu_rd_a5", 1'b0, 13'h0010, 16'h0, 1'b1, 1'b1, 1'b0);
    hps_check("hps_rd_3c", 1'b0, 13'h1FFF, 8'h00);
    cpu_check("cpu_rd_again", 1'b0, 13'h0010, 16'h0, 1'b1, 1'b0, 1'b0);
    // CPU was granted last, so this tie goes to the HPS.
    pair_check("pair2", 1'b0, 13'h0010, 8'h00, 1'b0, 13'h1FFF, 8'h00);

    // dirty_clear alone, then lds-only write is acknowledged but dropped.
    dirty_clear = 1'b1; tick(); dirty_clear = 1'b0; ref_dirty = 1'b0;
    chk("dirty_cleared", dirty, 0);
    cpu_check("cpu_lds_only", 1'b1, 13'h0010, 16'h00FF, 1'b0, 1'b1, 1'b0);
    cpu_check("cpu_rd_after_lds", 1'b0, 13'h0010, 16'h0, 1'b1, 1'b1, 1'b0);
    hps_check("hps_wr_nodirty", 1'b1, 13'h1FFF, 8'h3C);
    hps_check("hps_wr_5a", 1'b1, 13'h0123, 8'h5A);
    hps_check("hps_rd_5a", 1'b0, 13'h0123, 8'h00);

    // Write and dirty_clear in the same cycle: the write wins.
    cpu_check("cpu_wr_dclr", 1'b1, 13'h0020, 16'h7E00, 1'b1, 1'b0, 1'b1);
    dirty_clear = 1'b1; tick(); dirty_clear = 1'b0; ref_dirty = 1'b0;
    chk("dirty_clear_alone", dirty, 0);

    // cs withdrawn before DTACK on a read: access completes, no ack.
    cpu_addr = 13'h0010; cpu_write_strobe = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_cs = 1'b1;
    tick();
    cpu_cs = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_rd_no_ack", cpu_bus_ack, 0);
    end
    ref_last_hps = 1'b0;
    // cs withdrawn right as a write is acknowledged: the write stays.
    cpu_addr = 13'h0030; cpu_din = 16'h9900; cpu_write_strobe = 1'b1; cpu_uds = 1'b1; cpu_cs = 1'b1;
    tick();
    cpu_cs = 1'b0; cpu_uds = 1'b0; cpu_write_strobe = 1'b0;
    #1;
    chk("abort_wr_ack_low", cpu_bus_ack, 0);
    tick(); tick();
    ref_mem[13'h0030] = 8'h99; written.push_back(13'h0030); ref_dirty = 1'b1; ref_last_hps = 1'b0;
    chk("abort_wr_dirty", dirty, 1);
    cpu_check("abort_wr_readback", 1'b0, 13'h0030, 16'h0, 1'b1, 1'b1, 1'b0);

    // Read data registers hold between accesses.
    hold_cpu = {ref_mem[13'h0030], ref_mem[13'h0030]};
    hps_check("hps_wr_hold", 1'b1, 13'h0400, 8'hC3);
    chk("cpu_dout_hold", cpu_dout, hold_cpu);
    hold_hps = ref_mem[13'h0123];
    hps_check("hps_rd_hold", 1'b0, 13'h0123, 8'h00);
    cpu_check("cpu_rd_hold", 1'b0, 13'h0020, 16'h0, 1'b1, 1'b1, 1'b0);
    chk("hps_dout_hold", hps_dout, hold_hps);

    // Reset while an HPS read is in service drops it silently.
    hps_addr = 13'h1FFF; hps_rd = 1'b1;
    tick();
    hps_rd = 1'b0;
    apply_reset();
    chk("rstmid_hps_ack", hps_ack, 0);
    chk("rstmid_hps_busy", hps_busy, 0);
    chk("rstmid_cpu_ack", cpu_bus_ack, 0);
    chk("rstmid_dirty", dirty, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rstmid_no_late_ack", hps_ack, 0);
    end
    cpu_check("rstmid_cpu_rd", 1'b0, 13'h0010, 16'h0, 1'b1, 1'b1, 1'b0);

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 4));
      ra = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      rb = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      case (op)
        0: begin
          bit u, l;
          u = 1'($urandom_range(0, 1));
          l = u ? 1'($urandom_range(0, 1)) : 1'b1;
          cpu_check("rnd_cpu_wr", 1'b1, ra, 16'($urandom), u, l,
                    ($urandom_range(0, 3) == 0));
        end
        1: cpu_check("rnd_cpu_rd", 1'b0, written[$urandom_range(0, written.size() - 1)],
                     16'h0, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        2: hps_check("rnd_hps_wr", 1'b1, ra, 8'($urandom));
        3: hps_check("rnd_hps_rd", 1'b0, written[$urandom_range(0, written.size() - 1)], 8'h00);
        default: pair_check("rnd_pair", 1'b1, ra, 8'($urandom), 1'b0,
                            written[$urandom_range(0, written.size() - 1)], 8'h00);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
